hybrid_cache_line: RTL and testbench

Single cache line of the hybrid cache: holds one aligned region of 2^LSBBITS bytes, serves data-cache reads/writes and instruction-cache reads from that region, and on controller command writes itself back to memory (flush) or loads a new region (fill). It sits between the D/I-cache request ports and the shared memory port; the cache controller picks victims using the line's age (TTL) and dirty status.

---
 rtl/hybrid_cache_line_pkg.sv | 39 +++
 rtl/hybrid_cache_line_if.sv | 24 ++
 rtl/hybrid_cache_line_ram.sv | 46 ++++
 rtl/hybrid_cache_line.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_hybrid_cache_line.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hybrid_cache_line_pkg.sv
// Shared definitions for the hybrid cache line.
//   - default widths for the line parameters
//   - write-size codes and the line FSM state encoding
//   - lane_enables(): byte-enable mask for a D-cache write of a given size
package hybrid_cache_pkg;

   localparam int DEF_ADDRBITS    = 32;
   localparam int DEF_DATABITS    = 32;
   localparam int DEF_LSBBITS     = 7;
   localparam int DEF_TTLBITS     = 8;
   localparam int DEF_WORDLENBITS = 2;

   typedef enum logic [1:0] {
      WL_BYTE     = 2'b00,
      WL_HALF     = 2'b01,
      WL_WORD     = 2'b10,
      WL_WORD_ALT = 2'b11
   } wordlen_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_FILL  = 2'd2
   } line_state_e;

   // Little-endian lanes: a byte picks lane addr[1:0], a half picks the
   // upper or lower pair by addr[1], anything else writes the full word.
   function automatic logic [3:0] lane_enables(input logic [1:0] wordlen,
                                               input logic [1:0] byte_off);
      logic [3:0] be;
      case (wordlen)
         WL_BYTE: be = 4'b0001 << byte_off;
         WL_HALF: be = byte_off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/hybrid_cache_line_if.sv
// Memory-side bus of a cache line.
//   master (cache line): drives mem_addr (word address), mem_in, mem_wrreq, mem_rdreq
//   slave  (memory)    : drives mem_out, mem_out_valid
interface hybrid_cache_line_if #(
   parameter int ADDRBITS = 32,
   parameter int DATABITS = 32
);
   logic [ADDRBITS-1:0] mem_addr;
   logic [DATABITS-1:0] mem_in;
   logic [DATABITS-1:0] mem_out;
   logic                mem_out_valid;
   logic                mem_wrreq;
   logic                mem_rdreq;

   modport master (
      output mem_addr, mem_in, mem_wrreq, mem_rdreq,
      input  mem_out, mem_out_valid
   );

   modport slave (
      input  mem_addr, mem_in, mem_wrreq, mem_rdreq,
      output mem_out, mem_out_valid
   );
endinterface

// File: rtl/hybrid_cache_line_ram.sv
// Word storage of one cache line.
//   clk, reset        : clock, synchronous active-high reset (read register only)
//   rd_addr / rd_data : registered read port, data valid the cycle after rd_addr
//   we, wr_addr,
//   wr_be, wr_data    : byte-enabled write port
module cache_line_ram #(
   parameter int DATABITS = 32,
   parameter int IDXBITS  = 5
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [IDXBITS-1:0]    rd_addr,
   output logic [DATABITS-1:0]   rd_data,
   input  logic                  we,
   input  logic [IDXBITS-1:0]    wr_addr,
   input  logic [DATABITS/8-1:0] wr_be,
   input  logic [DATABITS-1:0]   wr_data
);
   localparam int WORDS = 1 << IDXBITS;
   localparam int LANES = DATABITS / 8;

   logic [DATABITS-1:0] mem_array [WORDS];
   logic [DATABITS-1:0] rd_data_reg;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < LANES; i++) begin
            if (wr_be[i]) begin
               mem_array[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
         end
      end
   end

   // Output register is cleared on reset so the shared read bus idles at 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_reg <= '0;
      end else begin
         rd_data_reg <= mem_array[rd_addr];
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/hybrid_cache_line.sv
// One line of the hybrid cache: serves D-cache reads/writes and I-cache
// reads from its region, writes itself back (flush) or loads a new region
// (fill) on controller command.
//   clk, reset                 : clock, synchronous active-high reset
//   dcache_line_* / icache_*   : request ports; *_out_valid flags the owner of cache_line_out
//   cache_line_dirty/miss/ttl  : status for the controller's victim selection
//   cache_line_flush/fill      : commands, accepted while cache_line_ready
//   cache_line_pause           : stalls memory transfers
//   cache_new_region           : byte address of the region to fill
//   mem                        : memory bus (word addresses)
module hybrid_cache_line
   import hybrid_cache_pkg::*;
#(
   parameter int ADDRBITS    = DEF_ADDRBITS,
   parameter int DATABITS    = DEF_DATABITS,
   parameter int LSBBITS     = DEF_LSBBITS,
   parameter int MAXLSBVALUE = (1 << LSBBITS) - 4,
   parameter int TTLBITS     = DEF_TTLBITS,
   parameter int MAXTTL      = (1 << TTLBITS) - 1,
   parameter int WORDLENBITS = DEF_WORDLENBITS
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDRBITS-1:0]    dcache_line_rdaddr,
   input  logic                   dcache_line_rdreq,
   output logic                   dcache_line_out_valid,
   input  logic [ADDRBITS-1:0]    dcache_line_wraddr,
   input  logic [DATABITS-1:0]    dcache_line_in,
   input  logic [WORDLENBITS-1:0] dcache_line_in_wordlen,
   input  logic                   dcache_line_wrreq,
   input  logic [ADDRBITS-1:0]    icache_line_rdaddr,
   input  logic                   icache_line_rdreq,
   output logic                   icache_line_out_valid,
   output logic [DATABITS-1:0]    cache_line_out,
   output logic                   cache_line_dirty,
   output logic                   cache_line_miss,
   input  logic                   cache_line_flush,
   input  logic                   cache_line_fill,
   input  logic                   cache_line_pause,
   output logic [TTLBITS-1:0]     cache_line_ttl,
   input  logic [ADDRBITS-1:0]    cache_new_region,
   output logic                   cache_line_ready,
   hybrid_cache_line_if.master    mem
);
   localparam int TAGBITS = ADDRBITS - LSBBITS;
   localparam int IDXBITS = LSBBITS - 2;
   localparam int LANES   = DATABITS / 8;
   localparam logic [IDXBITS-1:0] LAST_IDX   = IDXBITS'(MAXLSBVALUE >> 2);
   localparam logic [TTLBITS-1:0] TTL_RELOAD = TTLBITS'(MAXTTL);

   line_state_e        state_reg, state_next;
   logic [TAGBITS-1:0] tag_reg, tag_next;
   logic [TAGBITS-1:0] fill_tag_reg, fill_tag_next;
   logic               valid_reg, valid_next;
   logic               dirty_reg, dirty_next;
   logic               fill_pending_reg, fill_pending_next;
   logic [TTLBITS-1:0] ttl_reg, ttl_next;
   logic [IDXBITS-1:0] idx_reg, idx_next;
   logic               d_valid_reg, d_valid_next;
   logic               i_valid_reg, i_valid_next;
   logic               miss_reg, miss_next;

   // RAM port controls
   logic [IDXBITS-1:0]  ram_rd_addr;
   logic [DATABITS-1:0] ram_rd_data;
   logic                ram_we;
   logic [IDXBITS-1:0]  ram_wr_addr;
   logic [LANES-1:0]    ram_be;
   logic [DATABITS-1:0] ram_wdata;

   // Memory bus drive
   logic [ADDRBITS-1:0] bus_addr;
   logic                bus_wrreq;
   logic                bus_rdreq;

   // ------------------------------------------------------------------
   // Lookups. A command cycle takes precedence over requests: requests
   // presented alongside a command are ignored and simply held by the
   // requester until the line is ready again.
   // ------------------------------------------------------------------
   logic cmd, serve;
   logic d_rd_hit, d_wr_hit, i_rd_hit, any_req, any_hit;

   assign cmd   = cache_line_flush | cache_line_fill;
   assign serve = (state_reg == ST_IDLE) && !cmd;

   assign d_rd_hit = serve && dcache_line_rdreq && valid_reg &&
                     (dcache_line_rdaddr[ADDRBITS-1:LSBBITS] == tag_reg);
   assign d_wr_hit = serve && dcache_line_wrreq && valid_reg &&
                     (dcache_line_wraddr[ADDRBITS-1:LSBBITS] == tag_reg);
   assign i_rd_hit = serve && icache_line_rdreq && valid_reg &&
                     (icache_line_rdaddr[ADDRBITS-1:LSBBITS] == tag_reg);
   assign any_req  = serve && (dcache_line_rdreq | dcache_line_wrreq | icache_line_rdreq);
   assign any_hit  = d_rd_hit | d_wr_hit | i_rd_hit;

   // ------------------------------------------------------------------
   // D write lane steering: replicate the right-aligned data onto every
   // lane it may land on; the byte enables pick the real target.
   // ------------------------------------------------------------------
   logic [LANES-1:0]    req_be;
   logic [DATABITS-1:0] req_wdata;
   logic [1:0]          req_wordlen;

   assign req_wordlen = dcache_line_in_wordlen[1:0];
   assign req_be      = lane_enables(req_wordlen, dcache_line_wraddr[1:0]);

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign req_wdata[gi*8 +: 8] =
            (req_wordlen == WL_BYTE) ? dcache_line_in[7:0] :
            (req_wordlen == WL_HALF) ? dcache_line_in[(gi % 2)*8 +: 8] :
                                       dcache_line_in[gi*8 +: 8];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next        = state_reg;
      tag_next          = tag_reg;
      fill_tag_next     = fill_tag_reg;
      valid_next        = valid_reg;
      dirty_next        = dirty_reg;
      fill_pending_next = fill_pending_reg;
      ttl_next          = ttl_reg;
      idx_next          = idx_reg;
      d_valid_next      = 1'b0;
      i_valid_next      = 1'b0;
      miss_next         = 1'b0;

      ram_rd_addr = '0;
      ram_we      = 1'b0;
      ram_wr_addr = dcache_line_wraddr[LSBBITS-1:2];
      ram_be      = req_be;
      ram_wdata   = req_wdata;

      bus_addr  = '0;
      bus_wrreq = 1'b0;
      bus_rdreq = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (any_hit) begin
               ttl_next = TTL_RELOAD;
            end else if (ttl_reg != '0) begin
               ttl_next = ttl_reg - TTLBITS'(1);
            end

            if (cmd) begin
               // Word 0 is fetched now so it is on the RAM output for the
               // first write-back cycle.
               ram_rd_addr       = '0;
               idx_next          = '0;
               fill_pending_next = cache_line_fill;
               if (cache_line_fill) begin
                  fill_tag_next = cache_new_region[ADDRBITS-1:LSBBITS];
               end
               if (dirty_reg) begin
                  state_next = ST_FLUSH;
               end else if (cache_line_fill) begin
                  state_next = ST_FILL;
                  valid_next = 1'b0;
               end
            end else begin
               // D read owns the read port when it hits, otherwise I read.
               ram_rd_addr  = d_rd_hit ? dcache_line_rdaddr[LSBBITS-1:2]
                                       : icache_line_rdaddr[LSBBITS-1:2];
               ram_we       = d_wr_hit;
               d_valid_next = d_rd_hit;
               i_valid_next = i_rd_hit && !d_rd_hit;
               miss_next    = any_req && !any_hit;
               if (d_wr_hit) begin
                  dirty_next = 1'b1;
               end
            end
         end

         ST_FLUSH: begin
            bus_addr  = {2'b00, tag_reg, idx_reg};
            bus_wrreq = !cache_line_pause;
            // RAM output must hold word idx during the cycle it is written
            // out, so prefetch the next word only when this one advances.
            ram_rd_addr = cache_line_pause ? idx_reg : idx_reg + IDXBITS'(1);
            if (!cache_line_pause) begin
               idx_next = idx_reg + IDXBITS'(1);
               if (idx_reg == LAST_IDX) begin
                  idx_next   = '0;
                  dirty_next = 1'b0;
                  if (fill_pending_reg) begin
                     state_next = ST_FILL;
                     valid_next = 1'b0;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end
            end
         end

         ST_FILL: begin
            bus_addr    = {2'b00, fill_tag_reg, idx_reg};
            bus_rdreq   = !cache_line_pause;
            ram_wr_addr = idx_reg;
            ram_be      = '1;
            ram_wdata   = mem.mem_out;
            if (!cache_line_pause && mem.mem_out_valid) begin
               ram_we   = 1'b1;
               idx_next = idx_reg + IDXBITS'(1);
               if (idx_reg == LAST_IDX) begin
                  idx_next          = '0;
                  tag_next          = fill_tag_reg;
                  valid_next        = 1'b1;
                  dirty_next        = 1'b0;
                  ttl_next          = TTL_RELOAD;
                  fill_pending_next = 1'b0;
                  state_next        = ST_IDLE;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         tag_reg          <= '0;
         fill_tag_reg     <= '0;
         valid_reg        <= 1'b0;
         dirty_reg        <= 1'b0;
         fill_pending_reg <= 1'b0;
         ttl_reg          <= '0;
         idx_reg          <= '0;
         d_valid_reg      <= 1'b0;
         i_valid_reg      <= 1'b0;
         miss_reg         <= 1'b0;
      end else begin
         state_reg        <= state_next;
         tag_reg          <= tag_next;
         fill_tag_reg     <= fill_tag_next;
         valid_reg        <= valid_next;
         dirty_reg        <= dirty_next;
         fill_pending_reg <= fill_pending_next;
         ttl_reg          <= ttl_next;
         idx_reg          <= idx_next;
         d_valid_reg      <= d_valid_next;
         i_valid_reg      <= i_valid_next;
         miss_reg         <= miss_next;
      end
   end

   cache_line_ram #(
      .DATABITS (DATABITS),
      .IDXBITS  (IDXBITS)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_rd_data),
      .we      (ram_we),
      .wr_addr (ram_wr_addr),
      .wr_be   (ram_be),
      .wr_data (ram_wdata)
   );

   assign dcache_line_out_valid = d_valid_reg;
   assign icache_line_out_valid = i_valid_reg;
   assign cache_line_out        = ram_rd_data;
   assign cache_line_dirty      = dirty_reg;
   assign cache_line_miss       = miss_reg;
   assign cache_line_ttl        = ttl_reg;
   assign cache_line_ready      = (state_reg == ST_IDLE);

   assign mem.mem_addr  = bus_addr;
   assign mem.mem_in    = ram_rd_data;
   assign mem.mem_wrreq = bus_wrreq;
   assign mem.mem_rdreq = bus_rdreq;

   // Byte-offset bits of read addresses and the region offset carry no
   // information for this line.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{dcache_line_rdaddr[1:0], icache_line_rdaddr[1:0],
                               cache_new_region[LSBBITS-1:0]};

endmodule

// File: tb/tb_hybrid_cache_line.sv
// Scoreboard bench for hybrid_cache_line: stimulus pushes expected read data,
// misses, memory writes and fill read addresses into queues; a negedge
// monitor pops and compares whenever the DUT presents one of them.
module tb_hybrid_cache_line;
   import hybrid_cache_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] d_rdaddr = '0, d_wraddr = '0, d_in = '0, i_rdaddr = '0, new_region = '0;
   logic        d_rdreq = 1'b0, d_wrreq = 1'b0, i_rdreq = 1'b0;
   logic        flush = 1'b0, fill = 1'b0, pause = 1'b0;
   logic [1:0]  wordlen = 2'b00;

   logic        d_valid, i_valid, line_dirty, line_miss, line_ready;
   logic [31:0] line_out;
   logic [7:0]  line_ttl;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_d[$];
   logic [31:0] exp_i[$];
   logic [31:0] exp_miss[$];
   logic [31:0] exp_rd_addr[$];
   logic [63:0] exp_wr[$];

   hybrid_cache_line_if #(.ADDRBITS(32), .DATABITS(32)) mem_bus ();

   // Zero-wait memory: word at word-address a holds 0x1000_0000 + a.
   assign mem_bus.mem_out       = 32'h1000_0000 + mem_bus.mem_addr;
   assign mem_bus.mem_out_valid = mem_bus.mem_rdreq;

   hybrid_cache_line dut (
      .clk                    (clk),
      .reset                  (reset),
      .dcache_line_rdaddr     (d_rdaddr),
      .dcache_line_rdreq      (d_rdreq),
      .dcache_line_out_valid  (d_valid),
      .dcache_line_wraddr     (d_wraddr),
      .dcache_line_in         (d_in),
      .dcache_line_in_wordlen (wordlen),
      .dcache_line_wrreq      (d_wrreq),
      .icache_line_rdaddr     (i_rdaddr),
      .icache_line_rdreq      (i_rdreq),
      .icache_line_out_valid  (i_valid),
      .cache_line_out         (line_out),
      .cache_line_dirty       (line_dirty),
      .cache_line_miss        (line_miss),
      .cache_line_flush       (flush),
      .cache_line_fill        (fill),
      .cache_line_pause       (pause),
      .cache_line_ttl         (line_ttl),
      .cache_new_region       (new_region),
      .cache_line_ready       (line_ready),
      .mem                    (mem_bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end else begin
         $display("check %s: %08h", name, act);
      end
   endtask

   // Waits for ready with a cycle budget; pause is raised for p_len cycles
   // starting p_start cycles into the busy period.
   task automatic wait_ready(input int p_start, input int p_len, output int cnt);
      cnt = 0;
      while (!line_ready && cnt < 500) begin
         pause = (cnt >= p_start) && (cnt < p_start + p_len);
         tick();
         cnt++;
      end
      pause = 1'b0;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      logic [31:0] e;
      logic [63:0] w;
      if (d_valid) begin
         checks++;
         if (exp_d.size() == 0) begin
            errors++;
            $display("FAIL d_read: unexpected valid, data %08h", line_out);
         end else begin
            e = exp_d.pop_front();
            if (line_out !== e) begin
               errors++;
               $display("FAIL d_read: got %08h expected %08h", line_out, e);
            end else $display("d_read data=%08h", line_out);
         end
      end
      if (i_valid) begin
         checks++;
         if (exp_i.size() == 0) begin
            errors++;
            $display("FAIL i_read: unexpected valid, data %08h", line_out);
         end else begin
            e = exp_i.pop_front();
            if (line_out !== e) begin
               errors++;
               $display("FAIL i_read: got %08h expected %08h", line_out, e);
            end else $display("i_read data=%08h", line_out);
         end
      end
      if (line_miss) begin
         checks++;
         if (exp_miss.size() == 0) begin
            errors++;
            $display("FAIL miss: unexpected miss got 1 expected 0");
         end else begin
            e = exp_miss.pop_front();
            $display("miss addr=%08h", e);
         end
      end
      if (mem_bus.mem_wrreq) begin
         checks++;
         if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL mem_write: unexpected addr %08h data %08h", mem_bus.mem_addr, mem_bus.mem_in);
         end else begin
            w = exp_wr.pop_front();
            if ({mem_bus.mem_addr, mem_bus.mem_in} !== w) begin
               errors++;
               $display("FAIL mem_write: got addr %08h data %08h expected addr %08h data %08h",
                        mem_bus.mem_addr, mem_bus.mem_in, w[63:32], w[31:0]);
            end else $display("mem_write addr=%08h data=%08h", mem_bus.mem_addr, mem_bus.mem_in);
         end
      end
      if (mem_bus.mem_rdreq) begin
         // A fill read must never start while write-back words are still owed.
         checks++;
         if (exp_wr.size() != 0) begin
            errors++;
            $display("FAIL flush_before_fill: got read with %0d writes pending expected 0", exp_wr.size());
         end
         checks++;
         if (exp_rd_addr.size() == 0) begin
            errors++;
            $display("FAIL mem_read: unexpected addr %08h", mem_bus.mem_addr);
         end else begin
            e = exp_rd_addr.pop_front();
            if (mem_bus.mem_addr !== e) begin
               errors++;
               $display("FAIL mem_read: got addr %08h expected %08h", mem_bus.mem_addr, e);
            end else $display("mem_read addr=%08h", mem_bus.mem_addr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int cnt;
      logic [31:0] wd;

      repeat (3) tick();
      reset = 1'b0;

      // Reset state
      check("reset_ready",  32'(line_ready), 32'd1);
      check("reset_ttl",    32'(line_ttl),   32'd0);
      check("reset_dirty",  32'(line_dirty), 32'd0);
      check("reset_dvalid", 32'(d_valid),    32'd0);
      check("reset_miss",   32'(line_miss),  32'd0);
      check("reset_wrreq",  32'(mem_bus.mem_wrreq), 32'd0);
      check("reset_rdreq",  32'(mem_bus.mem_rdreq), 32'd0);
      check("reset_out",    line_out, 32'd0);

      // D read on an invalid line misses
      d_rdreq = 1'b1; d_rdaddr = 32'h0; exp_miss.push_back(32'h0);
      tick(); d_rdreq = 1'b0; tick();

      // Fill region 0x80 (word addresses 0x20..0x3F)
      new_region = 32'h80; fill = 1'b1;
      for (int i = 0; i < 32; i++) exp_rd_addr.push_back(32'h20 + 32'(i));
      tick(); fill = 1'b0;
      wait_ready(0, 0, cnt);
      check("fill_busy_cycles", 32'(cnt), 32'd32);
      check("fill_ttl",   32'(line_ttl),   32'd255);
      check("fill_dirty", 32'(line_dirty), 32'd0);

      // D read hit
      d_rdreq = 1'b1; d_rdaddr = 32'h84; exp_d.push_back(32'h1000_0021);
      tick(); d_rdreq = 1'b0; tick();

      // D and I hit together: only D gets the bus
      d_rdreq = 1'b1; d_rdaddr = 32'h84; i_rdreq = 1'b1; i_rdaddr = 32'h88;
      exp_d.push_back(32'h1000_0021);
      tick(); d_rdreq = 1'b0; i_rdreq = 1'b0; tick();
      i_rdreq = 1'b1; i_rdaddr = 32'h88; exp_i.push_back(32'h1000_0022);
      tick(); i_rdreq = 1'b0; tick();

      // Byte write, then read back next cycle
      d_wrreq = 1'b1; d_wraddr = 32'h85; d_in = 32'h0000_00AB; wordlen = 2'b00;
      tick(); d_wrreq = 1'b0;
      check("byte_write_dirty", 32'(line_dirty), 32'd1);
      d_rdreq = 1'b1; d_rdaddr = 32'h84; exp_d.push_back(32'h1000_AB21);
      tick(); d_rdreq = 1'b0;

      // Half write to upper half (addr[0] ignored)
      d_wrreq = 1'b1; d_wraddr = 32'h86; d_in = 32'h0000_1234; wordlen = 2'b01;
      tick(); d_wrreq = 1'b0;
      d_rdreq = 1'b1; d_rdaddr = 32'h84; exp_d.push_back(32'h1234_AB21);
      tick(); d_rdreq = 1'b0;

      // Word write with nonzero low address bits
      d_wrreq = 1'b1; d_wraddr = 32'h8B; d_in = 32'hDEAD_BEEF; wordlen = 2'b10;
      tick(); d_wrreq = 1'b0;
      d_rdreq = 1'b1; d_rdaddr = 32'h88; exp_d.push_back(32'hDEAD_BEEF);
      tick(); d_rdreq = 1'b0;

      // Write to another region misses
      d_wrreq = 1'b1; d_wraddr = 32'h200; d_in = 32'h55; wordlen = 2'b11;
      exp_miss.push_back(32'h200);
      tick(); d_wrreq = 1'b0; tick();

      // Flush with a 3-cycle pause mid-transfer
      for (int i = 0; i < 32; i++) begin
         wd = (i == 1) ? 32'h1234_AB21 : (i == 2) ? 32'hDEAD_BEEF : 32'h1000_0020 + 32'(i);
         exp_wr.push_back({32'h20 + 32'(i), wd});
      end
      flush = 1'b1; tick(); flush = 1'b0;
      wait_ready(5, 3, cnt);
      check("flush_busy_cycles", 32'(cnt), 32'd35);
      check("flush_dirty", 32'(line_dirty), 32'd0);
      tick();

      // Dirty the line, then fill a new region: write-back precedes fill
      d_wrreq = 1'b1; d_wraddr = 32'h80; d_in = 32'hCAFE_F00D; wordlen = 2'b10;
      tick(); d_wrreq = 1'b0;
      check("rewrite_dirty", 32'(line_dirty), 32'd1);
      for (int i = 0; i < 32; i++) begin
         wd = (i == 0) ? 32'hCAFE_F00D : (i == 1) ? 32'h1234_AB21 :
              (i == 2) ? 32'hDEAD_BEEF : 32'h1000_0020 + 32'(i);
         exp_wr.push_back({32'h20 + 32'(i), wd});
         exp_rd_addr.push_back(32'h40 + 32'(i));
      end
      new_region = 32'h100; fill = 1'b1; tick(); fill = 1'b0;
      wait_ready(0, 0, cnt);
      check("dirty_fill_busy_cycles", 32'(cnt), 32'd64);
      check("dirty_fill_ttl",   32'(line_ttl),   32'd255);
      check("dirty_fill_dirty", 32'(line_dirty), 32'd0);

      // TTL ages by one per idle cycle without hits
      repeat (10) tick();
      check("ttl_after_10_idle", 32'(line_ttl), 32'd245);

      d_rdreq = 1'b1; d_rdaddr = 32'h100; exp_d.push_back(32'h1000_0040);
      tick(); d_rdreq = 1'b0;
      check("ttl_reload_on_hit", 32'(line_ttl), 32'd255);
      d_rdreq = 1'b1; d_rdaddr = 32'h84; exp_miss.push_back(32'h84);
      tick(); d_rdreq = 1'b0; tick();

      // Reset in the middle of a fill
      new_region = 32'h180; fill = 1'b1;
      for (int i = 0; i < 6; i++) exp_rd_addr.push_back(32'h60 + 32'(i));
      tick(); fill = 1'b0;
      repeat (5) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      check("abort_ready", 32'(line_ready), 32'd1);
      check("abort_dirty", 32'(line_dirty), 32'd0);
      check("abort_ttl",   32'(line_ttl),   32'd0);
      d_rdreq = 1'b1; d_rdaddr = 32'h184; exp_miss.push_back(32'h184);
      tick(); d_rdreq = 1'b0; tick();

      repeat (3) tick();
      check("drain_d",    32'(exp_d.size()),       32'd0);
      check("drain_i",    32'(exp_i.size()),       32'd0);
      check("drain_miss", 32'(exp_miss.size()),    32'd0);
      check("drain_wr",   32'(exp_wr.size()),      32'd0);
      check("drain_rd",   32'(exp_rd_addr.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
